// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the clocked data-memory responder.
// Optional DMEM_BE_EN adds per-byte store enables.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  function automatic logic [29:0] word_idx(
    input logic [31:0] addr
  );
    return addr[31:2];
  endfunction

  // Upper address bits are never wrapped: any index past DEPTH is an error.
  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    return (addr[1:0] != 2'b00) ||
           ({2'b00, word_idx(addr)} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store with synchronous write and registered read.
// DMEM_BE_EN enables per-byte-lane writes.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          wr_en_i,
`ifdef DMEM_BE_EN
  input  logic [3:0]    wr_be_i,
`endif
  input  logic          rd_en_i,
  input  logic          clr_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
`ifdef DMEM_BE_EN
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wr_be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
`else
      mem_q[idx_i] <= wdata_i;
`endif
    end
  end

  // Clear wins so stores, errors and reset always leave zero behind.
  always_ff @(posedge CLK) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked word memory with WAIT_CYC wait states, one request in flight.
// Optional DMEM_BE_EN adds the req_be byte-enable input.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             err_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [3:0]       be_q;

  logic accept;
  logic commit;
  logic handshake;
  logic bad;
  logic wr_en;
  logic rd_en;
  logic clr;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign commit    = (state_q == BUSY) && (cnt_q == '0);
  assign handshake = valid_q && resp_ready;
  assign bad       = addr_err(addr_q, 32'(DEPTH));

  assign wr_en = RSTn && commit && we_q && !bad;
  assign rd_en = RSTn && commit && !we_q && !bad;
  assign clr   = !RSTn || handshake || (commit && (we_q || bad));

  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      we_q    <= req_we;
`ifdef DMEM_BE_EN
      be_q    <= req_be;
`else
      be_q    <= 4'hF;
`endif
    end
  end

  // Counter runs WAIT_CYC..0; the edge that sees zero commits.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= WAIT_INIT;
          end
        end
        (state_q == BUSY): begin
          if (commit) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            err_q   <= bad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        (state_q == RESP): begin
          if (handshake) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .CLK     (CLK),
    .wr_en_i (wr_en),
`ifdef DMEM_BE_EN
    .wr_be_i (be_q),
`endif
    .rd_en_i (rd_en),
    .clr_i   (clr),
    .idx_i   (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (resp_rdata)
  );

`ifndef DMEM_BE_EN
  logic unused_be;
  assign unused_be = ^be_q;
`endif

  assign resp_valid = valid_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYC=2 and WAIT_CYC=0 instances side by side.
// Byte-enable cases are included when DMEM_BE_EN is defined.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rstn [2];
  logic        rv   [2];
  logic        rwe  [2];
  logic        rr   [2];
  logic [31:0] ra   [2];
  logic [31:0] rwd  [2];
  logic        rdy  [2];
  logic        vld  [2];
  logic        er   [2];
  logic [31:0] rd   [2];
`ifdef DMEM_BE_EN
  logic [3:0]  rbe  [2];
`endif

  dmem_responder #(.DEPTH(256), .WAIT_CYC(2)) u0 (
    .CLK(CLK), .RSTn(rstn[0]),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
`ifdef DMEM_BE_EN
    .req_be(rbe[0]),
`endif
    .resp_valid(vld[0]), .resp_ready(rr[0]),
    .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYC(0)) u1 (
    .CLK(CLK), .RSTn(rstn[1]),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
`ifdef DMEM_BE_EN
    .req_be(rbe[1]),
`endif
    .resp_valid(vld[1]), .resp_ready(rr[1]),
    .resp_rdata(rd[1]), .resp_err(er[1])
  );

  int npass = 0;
  int ntot  = 0;

  // Reference: plain word array per instance plus "has been written" flags.
  logic [31:0] mdl [2][256];
  bit          kn  [2][256];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
    logic [31:0] erd;
    bit          eer;
  } vec_t;

  vec_t tbl [12];

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit ref_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 256);
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s (dut%0d): got %h expected %h", nm, d, act, exp);
  endtask

  task automatic mdl_store(input int d, input logic [31:0] a,
                           input logic [31:0] wdt, input logic [3:0] be);
    logic [3:0] ln;
    int idx;
    ln = be;
`ifndef DMEM_BE_EN
    ln = 4'hF;
`endif
    idx = a / 4;
    for (int b = 0; b < 4; b++)
      if (ln[b]) mdl[d][idx][8*b +: 8] = wdt[8*b +: 8];
    if (ln == 4'hF) kn[d][idx] = 1'b1;
  endtask

  task automatic txn(input int d, input bit w, input logic [31:0] a,
                     input logic [31:0] wdt, input logic [3:0] be,
                     input int hold, input bit chkd,
                     input logic [31:0] exp_rd, input bit exp_er,
                     output time tacc);
    int lat;
    logic [31:0] h_rd;
    logic h_er;
    check("ready before request", d, rdy[d], 1);
    rv[d] = 1'b1; rwe[d] = w; ra[d] = a; rwd[d] = wdt;
    rr[d] = (hold == 0);
`ifdef DMEM_BE_EN
    rbe[d] = be;
`endif
    @(posedge CLK);
    tacc = $time;
    #1;
    rv[d] = 1'b0;
    check("ready low after accept", d, rdy[d], 0);
    lat = 0;
    do begin
      @(posedge CLK); #1; lat++;
    end while (!vld[d] && lat < 40);
    check("latency edges", d, lat, wc(d) + 1);
    check("resp_err", d, er[d], exp_er);
    if (chkd) check("resp_rdata", d, rd[d], exp_rd);
    h_rd = rd[d]; h_er = er[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("held resp_valid", d, vld[d], 1);
      check("held resp_rdata", d, rd[d], h_rd);
      check("held resp_err", d, er[d], h_er);
      check("held req_ready", d, rdy[d], 0);
    end
    rr[d] = 1'b1;
    @(posedge CLK); #1;
    check("valid cleared", d, vld[d], 0);
    check("back to idle", d, rdy[d], 1);
    check("rdata cleared", d, rd[d], 0);
    check("err cleared", d, er[d], 0);
    rr[d] = 1'b0;
  endtask

  task automatic mtxn(input int d, input bit w, input logic [31:0] a,
                      input logic [31:0] wdt, input logic [3:0] be,
                      input int hold);
    bit e;
    bit ck;
    logic [31:0] x;
    time t;
    int idx;
    e = ref_err(a);
    idx = e ? 0 : int'(a / 4);
    x = 32'h0;
    ck = 1'b1;
    if (!w && !e) begin
      x = mdl[d][idx];
      ck = kn[d][idx];
    end
    txn(d, w, a, wdt, be, hold, ck, x, e, t);
    if (w && !e) mdl_store(d, a, wdt, be);
  endtask

  initial begin
    time t1, t2, tdummy;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h2,        32'h0,        0, 32'h0,        1'b1};
    tbl[3]  = '{1'b1, 32'h0,        32'h12345678, 0, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 32'h400,      32'hFFFFFFFF, 0, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h0,        32'h0,        0, 32'h12345678, 1'b0};
    tbl[6]  = '{1'b0, 32'h10,       32'h0,        5, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 32'h3FC,      32'hCAFEF00D, 0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h3FC,      32'h0,        1, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{1'b0, 32'h80000000, 32'h0,        0, 32'h0,        1'b1};
    tbl[10] = '{1'b1, 32'h13,       32'h01010101, 2, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; rv[d] = 1'b0; rwe[d] = 1'b0; rr[d] = 1'b0;
      ra[d] = '0; rwd[d] = '0;
`ifdef DMEM_BE_EN
      rbe[d] = 4'hF;
`endif
      for (int i = 0; i < 256; i++) begin
        mdl[d][i] = '0; kn[d][i] = 1'b0;
      end
    end
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset req_ready", d, rdy[d], 1);
      check("reset resp_valid", d, vld[d], 0);
      check("reset resp_rdata", d, rd[d], 0);
      check("reset resp_err", d, er[d], 0);
      rstn[d] = 1'b1;
    end

    // resp_ready while idle must not produce a response
    rr[0] = 1'b1; rr[1] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("idle resp_ready ignored", d, vld[d], 0);
      rr[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 12; i++) begin
        txn(d, tbl[i].w, tbl[i].a, tbl[i].wd, 4'hF, tbl[i].hold,
            1'b1, tbl[i].erd, tbl[i].eer, tdummy);
        if (tbl[i].w && !tbl[i].eer)
          mdl_store(d, tbl[i].a, tbl[i].wd, 4'hF);
      end

    // Reset while a store is in BUSY: the store must be abandoned
    txn(0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 0, 1'b1, 32'h0, 1'b0, tdummy);
    mdl_store(0, 32'h20, 32'hA5A5A5A5, 4'hF);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h55; rr[0] = 1'b1;
    @(posedge CLK); #1;
    rv[0] = 1'b0;
    check("busy req_ready", 0, rdy[0], 0);
    rstn[0] = 1'b0;
    @(posedge CLK); #1;
    rstn[0] = 1'b1;
    check("mid reset resp_valid", 0, vld[0], 0);
    check("mid reset req_ready", 0, rdy[0], 1);
    rr[0] = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("abandoned no resp", 0, vld[0], 0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b1, 32'hA5A5A5A5, 1'b0, tdummy);

    // Reset while a response is pending: it is dropped
    rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 32'h20; rr[0] = 1'b0;
    @(posedge CLK); #1;
    rv[0] = 1'b0;
    repeat (wc(0) + 1) @(posedge CLK);
    #1;
    check("pending resp_valid", 0, vld[0], 1);
    check("pending resp_rdata", 0, rd[0], 32'hA5A5A5A5);
    rstn[0] = 1'b0;
    @(posedge CLK); #1;
    rstn[0] = 1'b1;
    check("dropped resp_valid", 0, vld[0], 0);
    check("dropped resp_rdata", 0, rd[0], 0);

    // Back-to-back acceptances on the zero-wait instance
    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b1, 32'hDEADBEEF, 1'b0, t1);
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1, 32'h12345678, 1'b0, t2);
    check("acceptance spacing >= 2 cycles", 1, ((t2 - t1) >= 20), 1);

`ifdef DMEM_BE_EN
    txn(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 0, 1'b1, 32'h0, 1'b0, tdummy);
    mdl_store(0, 32'h8, 32'h11223344, 4'hF);
    txn(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, 1'b1, 32'h0, 1'b0, tdummy);
    mdl_store(0, 32'h8, 32'hAABBCCDD, 4'b0101);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, 1'b1, 32'h11BB33DD, 1'b0, tdummy);
    txn(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, 1'b1, 32'h0, 1'b0, tdummy);
    txn(0, 1'b0, 32'h8, 32'h0, 4'hA, 1, 1'b1, 32'h11BB33DD, 1'b0, tdummy);
`endif

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 50; i++) begin
        int sel;
        a = 32'($urandom_range(0, 15)) * 4;
        sel = $urandom_range(0, 9);
        if (sel == 0) a = a + 32'($urandom_range(1, 3));
        if (sel == 1) a = (32'd256 + 32'($urandom_range(0, 300))) * 4;
        mtxn(d, 1'($urandom_range(0, 1)), a, $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
